// File: rtl/spi_frame_master.sv
// Serialises one {wr, ext_addr, reg_addr, wdata} command into a 17-bit SPI frame on sclk,
// captures read data from miso and returns a single-cycle response with error status.
module spi_frame_master #(
    parameter int unsigned CS_GAP     = 1,
    parameter bit          FUTURE_BIT = 1'b0
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_wr,
    input  logic [2:0] cmd_ext_addr,
    input  logic [2:0] cmd_reg_addr,
    input  logic [7:0] cmd_wdata,
    output logic       cs,
    output logic       mosi,
    input  logic       miso,
    input  logic       miso_oe,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    // The IDLE cycle after GAP is itself a cs-low cycle, so GAP holds CS_GAP-1 cycles.
    localparam logic [3:0] GapLast = (CS_GAP > 1) ? 4'(CS_GAP - 2) : 4'd0;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  gap_q, gap_d;
    logic [16:0] frame_q, frame_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        oe_seen_q, oe_seen_d;
    logic        cs_q, cs_d;
    logic        mosi_q, mosi_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        frame_d     = frame_q;
        rdata_d     = rdata_q;
        oe_seen_d   = oe_seen_q;
        cs_d        = cs_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    frame_d   = {1'b0, cmd_wdata, cmd_reg_addr, FUTURE_BIT, cmd_ext_addr, cmd_wr};
                    cs_d      = 1'b1;
                    mosi_d    = cmd_wr;
                    cnt_d     = 5'd0;
                    oe_seen_d = 1'b0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                // Data phase: the edges after bits 9..16 have been driven.
                if (cnt_q >= 5'd9) begin
                    oe_seen_d = oe_seen_q | miso_oe;
                    if (!frame_q[0]) begin
                        rdata_d = {miso, rdata_q[7:1]};
                    end
                end
                if (cnt_q == 5'd16) begin
                    cs_d        = 1'b0;
                    mosi_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !oe_seen_d;
                    rsp_rdata_d = (frame_q[0] || !oe_seen_d) ? 8'h00 : rdata_d;
                    gap_d       = 4'd0;
                    state_d     = (CS_GAP > 1) ? StGap : StIdle;
                end else begin
                    cnt_d  = cnt_q + 5'd1;
                    mosi_d = frame_q[cnt_q + 5'd1];
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 5'd0;
            gap_q       <= 4'd0;
            frame_q     <= 17'd0;
            rdata_q     <= 8'h00;
            oe_seen_q   <= 1'b0;
            cs_q        <= 1'b0;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            frame_q     <= frame_d;
            rdata_q     <= rdata_d;
            oe_seen_q   <= oe_seen_d;
            cs_q        <= cs_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign cs        = cs_q;
    assign mosi      = mosi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Randomised bench for spi_frame_master: a cycle-level bus model with a slave bank checks
// cs/mosi/ready timing, and a scoreboard checks each response against the command.
module tb_spi_frame_master;

    localparam int unsigned GAP        = 3;
    localparam bit          FB         = 1'b0;
    localparam logic [7:0]  SLAVE_MASK = 8'b0110_1111;  // ext 4 and 7 unpopulated

    logic       sclk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_wr = 1'b0;
    logic [2:0] cmd_ext_addr = 3'd0;
    logic [2:0] cmd_reg_addr = 3'd0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cs, mosi;
    logic       miso = 1'bz;
    logic       miso_oe = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;

    spi_frame_master #(.CS_GAP(GAP), .FUTURE_BIT(FB)) dut (
        .sclk(sclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_ext_addr(cmd_ext_addr), .cmd_reg_addr(cmd_reg_addr),
        .cmd_wdata(cmd_wdata), .cs(cs), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 sclk = ~sclk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    // Shared between driver and bus model
    bit          en = 1'b0;
    bit          exp_b2b = 1'b0;
    bit          prev_hold = 1'b0;
    logic [7:0]  cur_sd = 8'h00;
    bit          active = 1'b0;
    int          a_cyc = 0;
    int          prev_a = -1000;
    logic [16:0] word = '0;
    logic [16:0] cap_word = '0;
    bit          present = 1'b0;
    logic [7:0]  sd = 8'h00;
    logic [8:0]  expq[$];
    int          n_rsp = 0;

    // Bus model: checks frame timing, plays the slave bank, records accepts.
    always @(negedge sclk) begin : bus
        int k;
        if (en) begin
            if (active) begin
                k = cyc - a_cyc;
                if (k <= 16) begin
                    chk("cs_frame", cs, 1);
                    chk("mosi_bit", mosi, word[k]);
                    cap_word[k] = mosi;
                end else if (k == 17) begin
                    chk("cs_end", cs, 0);
                    chk("mosi_end", mosi, 0);
                end
                chk("rsp_pulse", rsp_valid, 32'(k == 17));
                chk("ready_frame", cmd_ready, 32'(k >= 16 + int'(GAP)));
                chk("busy_frame", busy, 32'(k < 16 + int'(GAP)));
                if (k >= 16 + int'(GAP)) active = 1'b0;
                if (rst === 1'b1) begin
                    if (active && k < 17) void'(expq.pop_back());
                    active = 1'b0;
                    prev_a = -1000;
                end
            end else begin
                chk("cs_idle", cs, 0);
                chk("mosi_idle", mosi, 0);
                chk("rsp_idle", rsp_valid, 0);
                chk("ready_idle", cmd_ready, 1);
                chk("busy_idle", busy, 0);
            end
            k = cyc - a_cyc;
            if (active && present && k >= 9 && k <= 16) begin
                miso_oe = 1'b1;
                miso = sd[k-9];
            end else begin
                miso_oe = 1'b0;
                miso = 1'bz;
            end
            if (!active && cmd_valid === 1'b1 && cmd_ready === 1'b1 && rst === 1'b0) begin
                a_cyc = cyc + 1;
                if (exp_b2b && prev_a >= 0) chk("b2b_pitch", a_cyc - prev_a, 17 + GAP);
                prev_a = a_cyc;
                word = 17'(cmd_wr) | (17'(cmd_ext_addr) << 1) | (17'(FB) << 4)
                     | (17'(cmd_reg_addr) << 5) | (17'(cmd_wdata) << 8);
                present = SLAVE_MASK[cmd_ext_addr];
                sd = cur_sd;
                expq.push_back({!present, (cmd_wr || !present) ? 8'h00 : cur_sd});
                active = 1'b1;
            end
        end
    end

    // Response monitor
    always @(negedge sclk) begin : mon
        logic [8:0] e;
        if (en && rsp_valid === 1'b1) begin
            n_rsp++;
            if (expq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_unexpected at cycle %0d: got err=%b rdata=%h, want none",
                         cyc, rsp_err, rsp_rdata);
            end else begin
                e = expq.pop_front();
                chk("rsp_err", rsp_err, e[8]);
                chk("rsp_rdata", rsp_rdata, e[7:0]);
            end
        end
    end

    task automatic scramble();
        cmd_wr = 1'($urandom);
        cmd_ext_addr = 3'($urandom);
        cmd_reg_addr = 3'($urandom);
        cmd_wdata = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sclk);
            #1;
            scramble();
        end
    endtask

    task automatic issue(input bit wr, input logic [2:0] ext, input logic [2:0] rg,
                         input logic [7:0] wd, input logic [7:0] sdat, input bit hold);
        int t;
        cmd_wr = wr;
        cmd_ext_addr = ext;
        cmd_reg_addr = rg;
        cmd_wdata = wd;
        cur_sd = sdat;
        exp_b2b = prev_hold;
        cmd_valid = 1'b1;
        t = 0;
        do begin
            @(negedge sclk);
            t++;
        end while (!(cmd_ready === 1'b1 && rst === 1'b0) && t < 200);
        chk("accept_timeout", 32'(t >= 200), 0);
        @(posedge sclk);
        #1;
        cmd_valid = hold;
        prev_hold = hold;
        scramble();
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (active && t < 200) begin
            @(posedge sclk);
            t++;
        end
        chk("done_timeout", 32'(t >= 200), 0);
        #1;
    endtask

    initial begin
        int r0;
        rst = 1'b1;
        @(posedge sclk);
        #1;
        en = 1'b1;
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_ready", cmd_ready, 1);
        @(posedge sclk);
        #1;
        rst = 1'b0;
        idle(2);

        // Write ext=5 reg=3 wdata=0x3C
        issue(1'b1, 3'd5, 3'd3, 8'h3C, 8'h00, 1'b0);
        wait_done();
        chk("w_mosi_word", cap_word, 17'h03C6B);

        // Read with responding slave, then to an empty slot
        issue(1'b0, 3'd2, 3'd6, 8'h77, 8'hA5, 1'b0);
        wait_done();
        issue(1'b0, 3'd7, 3'd1, 8'h00, 8'h5A, 1'b0);
        wait_done();

        // Back-to-back with cmd_valid held and inputs scrambled while busy
        r0 = n_rsp;
        issue(1'b1, 3'd1, 3'd2, 8'h11, 8'h00, 1'b1);
        idle(8);
        issue(1'b0, 3'd3, 3'd4, 8'h22, 8'hC3, 1'b0);
        wait_done();
        idle(2);
        chk("b2b_pulses", n_rsp - r0, 2);

        // Reset at edge A+8 of a write aborts it silently
        r0 = n_rsp;
        issue(1'b1, 3'd5, 3'd0, 8'hF0, 8'h00, 1'b0);
        repeat (7) @(posedge sclk);
        #1;
        rst = 1'b1;
        @(posedge sclk);
        #1;
        rst = 1'b0;
        prev_hold = 1'b0;
        chk("abort_cs", cs, 0);
        chk("abort_mosi", mosi, 0);
        chk("abort_ready", cmd_ready, 1);
        idle(25);
        chk("abort_no_rsp", n_rsp - r0, 0);
        issue(1'b0, 3'd2, 3'd5, 8'h00, 8'hA5, 1'b0);
        wait_done();

        // rst wins over cmd_valid on the same edge
        cmd_valid = 1'b1;
        rst = 1'b1;
        @(posedge sclk);
        #1;
        rst = 1'b0;
        cmd_valid = 1'b0;
        chk("rst_vs_valid_busy", busy, 0);
        idle(3);

        for (int i = 0; i < 40; i++) begin
            bit hold;
            hold = ($urandom_range(0, 3) == 0);
            issue(1'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), hold);
            if (hold) idle(8);
            else idle($urandom_range(0, 25));
        end
        cmd_valid = 1'b0;
        prev_hold = 1'b0;
        wait_done();
        idle(3);
        chk("queue_empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
